// File: rtl/attack_arbiter.sv
// attack_arbiter: turns both players' attack button presses into a single
// stream of hits for the HP datapath. Each player holds at most one pending
// attack. Simultaneous requests are served round-robin over a valid/ready
// handshake, and each player is locked out for a cooldown after an accepted hit.
module attack_arbiter #(
   parameter int CNT_W    = 5,
   parameter int COOLDOWN = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       kick1,
   input  logic       fight1,
   input  logic       jump1,
   input  logic       kick2,
   input  logic       fight2,
   input  logic       jump2,
   input  logic       valid1,
   input  logic       valid2,
   input  logic       dodge1,
   input  logic       dodge2,
   input  logic       game_over,
   input  logic       hit_ready,
   output logic       hit_valid,
   output logic       hit_player,
   output logic [1:0] hit_type,
   output logic       hit_dodged,
   output logic       busy1,
   output logic       busy2
);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN);

   // Attack type codes as presented on hit_type.
   localparam logic [1:0] T_KICK  = 2'b01;
   localparam logic [1:0] T_FIGHT = 2'b10;
   localparam logic [1:0] T_JUMP  = 2'b11;

   // Per-player vectors: index 0 = P1, index 1 = P2; buttons ordered {jump, fight, kick}.
   logic [1:0][2:0]       btn;
   logic [1:0][2:0]       btn_q;
   logic [1:0][2:0]       rise;
   logic [1:0]            valid_v;
   logic [1:0]            dodge_v;

   logic [1:0]            pend_q, pend_d;
   logic [1:0][1:0]       type_q, type_d;
   logic [1:0][CNT_W-1:0] cd_q, cd_d;

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  hit_player_q, hit_player_d;
   logic [1:0]            hit_type_q, hit_type_d;
   logic                  hit_dodged_q, hit_dodged_d;

   logic                  winner;
   logic                  accept;

   assign btn[0]  = {jump1, fight1, kick1};
   assign btn[1]  = {jump2, fight2, kick2};
   assign rise[0] = btn[0] & ~btn_q[0];
   assign rise[1] = btn[1] & ~btn_q[1];
   assign valid_v = {valid2, valid1};
   assign dodge_v = {dodge2, dodge1};

   // Simultaneous rises resolve kick > fight > jump.
   function automatic logic [1:0] encode_type(input logic [2:0] r);
      if (r[0])      return T_KICK;
      else if (r[1]) return T_FIGHT;
      else if (r[2]) return T_JUMP;
      else           return 2'b00;
   endfunction

   // Pick the grant winner and decide whether the presented hit is consumed.
   always_comb begin
      if (pend_q == 2'b01)      winner = 1'b0;
      else if (pend_q == 2'b10) winner = 1'b1;
      else                      winner = ~last_grant_q;
      // game_over outranks the handshake: a flushed hit never loads a cooldown.
      accept = (state_q == ISSUE) && hit_ready && !game_over;
   end

   // Per-player pending capture, cooldown drain/reload and flush.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      pend_d = pend_q;
      type_d = type_q;
      cd_d   = cd_q;
      for (int p = 0; p < 2; p++) begin
         if (cd_q[p] != '0) cd_d[p] = cd_q[p] - 1'b1;
         if (game_over) begin
            pend_d[p] = 1'b0;
         end else if (accept && (hit_player_q == 1'(p))) begin
            pend_d[p] = 1'b0;
            cd_d[p]   = COOL_LOAD;
         end else if (!pend_q[p] && (cd_q[p] == '0) && valid_v[p] && (rise[p] != 3'b000)) begin
            // Rises that arrive while blocked are dropped, never queued.
            pend_d[p] = 1'b1;
            type_d[p] = encode_type(rise[p]);
         end
      end
   end

   // Issue FSM: grant in IDLE, hold the hit stable in ISSUE until handshake or flush.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      hit_player_d = hit_player_q;
      hit_type_d   = hit_type_q;
      hit_dodged_d = hit_dodged_q;
      unique case (state_q)
         IDLE: begin
            if (!game_over && (pend_q != 2'b00)) begin
               state_d      = ISSUE;
               hit_player_d = winner;
               hit_type_d   = type_q[winner];
               hit_dodged_d = dodge_v[~winner];
               last_grant_d = winner;
            end
         end
         ISSUE: begin
            if (game_over || hit_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (Reset) begin
         // Button history resets high so a button held through reset does not fire.
         btn_q        <= '1;
         pend_q       <= '0;
         type_q       <= '0;
         cd_q         <= '0;
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         hit_player_q <= 1'b0;
         hit_type_q   <= 2'b00;
         hit_dodged_q <= 1'b0;
      end else begin
         btn_q        <= btn;
         pend_q       <= pend_d;
         type_q       <= type_d;
         cd_q         <= cd_d;
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         hit_player_q <= hit_player_d;
         hit_type_q   <= hit_type_d;
         hit_dodged_q <= hit_dodged_d;
      end
   end

   assign hit_valid  = (state_q == ISSUE);
   assign hit_player = hit_player_q;
   assign hit_type   = hit_type_q;
   assign hit_dodged = hit_dodged_q;
   assign busy1      = pend_q[0] | (cd_q[0] != '0);
   assign busy2      = pend_q[1] | (cd_q[1] != '0);

endmodule

// File: tb/tb_attack_arbiter.sv
// Directed bench for attack_arbiter: reset behaviour, edge detection,
// round-robin ties, handshake stalls, cooldown length, dodge sampling,
// game_over flush and reset mid-issue.
module tb_attack_arbiter;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       kick1, fight1, jump1, kick2, fight2, jump2;
   logic       valid1, valid2, dodge1, dodge2, game_over, hit_ready;
   logic       hit_valid, hit_player, hit_dodged, busy1, busy2;
   logic [1:0] hit_type;

   int checks   = 0;
   int failures = 0;

   attack_arbiter #(.CNT_W(5), .COOLDOWN(16)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .kick1      (kick1),
      .fight1     (fight1),
      .jump1      (jump1),
      .kick2      (kick2),
      .fight2     (fight2),
      .jump2      (jump2),
      .valid1     (valid1),
      .valid2     (valid2),
      .dodge1     (dodge1),
      .dodge2     (dodge2),
      .game_over  (game_over),
      .hit_ready  (hit_ready),
      .hit_valid  (hit_valid),
      .hit_player (hit_player),
      .hit_type   (hit_type),
      .hit_dodged (hit_dodged),
      .busy1      (busy1),
      .busy2      (busy2)
   );

   always #5 Clk = ~Clk;

   // One clock edge, then settle so outputs are sampled away from the edge.
   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check a presented hit (or its absence).
   task automatic check_hit(input string tag, input logic v, input logic p, input logic [1:0] t);
      check({tag, ".valid"}, 8'(hit_valid), 8'(v));
      if (v) begin
         check({tag, ".player"}, 8'(hit_player), 8'(p));
         check({tag, ".type"}, 8'(hit_type), 8'(t));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".valid"},  8'(hit_valid),  8'd0);
      check({tag, ".player"}, 8'(hit_player), 8'd0);
      check({tag, ".type"},   8'(hit_type),   8'd0);
      check({tag, ".dodged"}, 8'(hit_dodged), 8'd0);
      check({tag, ".busy1"},  8'(busy1),      8'd0);
      check({tag, ".busy2"},  8'(busy2),      8'd0);
   endtask

   // Bounded wait for both players to become free.
   task automatic wait_free(input string tag);
      int n = 0;
      while ((busy1 || busy2) && n < 64) begin
         cyc();
         n++;
      end
      check({tag, ".free"}, {6'd0, busy1, busy2}, 8'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      Reset = 1'b1;
      kick1 = 1'b1; fight1 = 1'b0; jump1 = 1'b0;
      kick2 = 1'b0; fight2 = 1'b0; jump2 = 1'b0;
      valid1 = 1'b1; valid2 = 1'b1; dodge1 = 1'b0; dodge2 = 1'b0;
      game_over = 1'b0; hit_ready = 1'b1;

      // ---- 1: reset with kick1 held, then a clean press ----
      cyc(); cyc();
      check_reset_outputs("t1_reset");
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check_hit("t1_held", 1'b0, 1'b0, 2'b00);
         check("t1_held.busy1", 8'(busy1), 8'd0);
      end
      kick1 = 1'b0; cyc();
      kick1 = 1'b1; cyc();                 // rise captured
      check("t1_pend.busy1", 8'(busy1), 8'd1);
      check_hit("t1_pend", 1'b0, 1'b0, 2'b00);
      cyc();                               // granted
      check_hit("t1_issue", 1'b1, 1'b0, 2'b01);
      check("t1_issue.dodged", 8'(hit_dodged), 8'd0);
      kick1 = 1'b0; cyc();                 // accepted
      check_hit("t1_acc", 1'b0, 1'b0, 2'b00);
      check("t1_acc.busy1", 8'(busy1), 8'd1);
      for (int i = 0; i < 15; i++) begin
         cyc();
         check("t1_cool.busy1", 8'(busy1), 8'd1);
      end
      cyc();
      check("t1_cool_end.busy1", 8'(busy1), 8'd0);

      // ---- 2: ties; last grant was P1, so P2 wins both rounds ----
      for (int r = 0; r < 2; r++) begin
         kick1 = 1'b1; fight2 = 1'b1; cyc();
         check("t2_pend.busy1", 8'(busy1), 8'd1);
         check("t2_pend.busy2", 8'(busy2), 8'd1);
         kick1 = 1'b0; fight2 = 1'b0; cyc();
         check_hit("t2_first", 1'b1, 1'b1, 2'b10);
         cyc();
         check_hit("t2_gap", 1'b0, 1'b0, 2'b00);
         check("t2_gap.busy1", 8'(busy1), 8'd1);
         cyc();
         check_hit("t2_second", 1'b1, 1'b0, 2'b01);
         cyc();
         check_hit("t2_done", 1'b0, 1'b0, 2'b00);
         wait_free("t2");
      end

      // ---- 3: stalled handshake, re-presses dropped ----
      hit_ready = 1'b0;
      kick1 = 1'b1; cyc(); cyc();
      check_hit("t3_issue", 1'b1, 1'b0, 2'b01);
      for (int i = 0; i < 5; i++) begin
         kick1 = i[0];
         cyc();
         check_hit("t3_stall", 1'b1, 1'b0, 2'b01);
         check("t3_stall.dodged", 8'(hit_dodged), 8'd0);
      end
      hit_ready = 1'b1; kick1 = 1'b0; cyc();
      check_hit("t3_acc", 1'b0, 1'b0, 2'b00);
      cyc();
      check_hit("t3_after", 1'b0, 1'b0, 2'b00);

      // ---- 4: press during cooldown dropped; exact cooldown; press at zero issues ----
      cyc(); cyc(); cyc();
      jump1 = 1'b1; cyc();
      check_hit("t4_drop", 1'b0, 1'b0, 2'b00);
      jump1 = 1'b0; cyc();
      check_hit("t4_drop2", 1'b0, 1'b0, 2'b00);
      n = 0;
      while (busy1 && n < 64) begin
         cyc();
         n++;
      end
      check("t4_cool_left", 8'(n), 8'd10);
      jump1 = 1'b1; cyc();
      check("t4_pend.busy1", 8'(busy1), 8'd1);
      cyc();
      check_hit("t4_issue", 1'b1, 1'b0, 2'b11);
      cyc();
      check_hit("t4_acc", 1'b0, 1'b0, 2'b00);
      jump1 = 1'b0;

      // ---- 5: dodge of the target sampled at grant only ----
      wait_free("t5");
      fight1 = 1'b1; dodge2 = 1'b1; hit_ready = 1'b0; cyc(); cyc();
      check_hit("t5_issue", 1'b1, 1'b0, 2'b10);
      check("t5_issue.dodged", 8'(hit_dodged), 8'd1);
      dodge2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         check("t5_hold.dodged", 8'(hit_dodged), 8'd1);
         check_hit("t5_hold", 1'b1, 1'b0, 2'b10);
      end
      hit_ready = 1'b1; fight1 = 1'b0; cyc();
      check_hit("t5_acc", 1'b0, 1'b0, 2'b00);

      // ---- 6: game_over flush, then reset mid-issue ----
      jump2 = 1'b1; hit_ready = 1'b0; cyc(); cyc();
      check_hit("t6_issue", 1'b1, 1'b1, 2'b11);
      game_over = 1'b1; cyc();
      check_hit("t6_flush", 1'b0, 1'b0, 2'b00);
      check("t6_flush.busy2", 8'(busy2), 8'd0);
      jump2 = 1'b0; cyc();
      kick2 = 1'b1; cyc();
      check_hit("t6_blocked", 1'b0, 1'b0, 2'b00);
      check("t6_blocked.busy2", 8'(busy2), 8'd0);
      cyc();
      check_hit("t6_blocked2", 1'b0, 1'b0, 2'b00);
      game_over = 1'b0; hit_ready = 1'b1; cyc(); cyc();
      check_hit("t6_resume", 1'b0, 1'b0, 2'b00);
      check("t6_resume.busy2", 8'(busy2), 8'd0);

      kick2 = 1'b0; cyc();
      kick2 = 1'b1; hit_ready = 1'b0; dodge1 = 1'b1; cyc(); cyc();
      check_hit("t6_issue2", 1'b1, 1'b1, 2'b01);
      check("t6_issue2.dodged", 8'(hit_dodged), 8'd1);
      Reset = 1'b1; cyc();
      check_reset_outputs("t6_reset");
      Reset = 1'b0; dodge1 = 1'b0; cyc(); cyc();
      check_hit("t6_held", 1'b0, 1'b0, 2'b00);

      // After reset the last grant is P2, so P1 wins the tie.
      kick2 = 1'b0; cyc();
      kick1 = 1'b1; fight2 = 1'b1; hit_ready = 1'b1; cyc(); cyc();
      check_hit("t6_tie_first", 1'b1, 1'b0, 2'b01);
      kick1 = 1'b0; fight2 = 1'b0; cyc();
      check_hit("t6_tie_gap", 1'b0, 1'b0, 2'b00);
      cyc();
      check_hit("t6_tie_second", 1'b1, 1'b1, 2'b10);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
